pmu_spi_slave_emu: RTL
======================

# pmu_spi_slave_emu

SPI responder that emulates the AD5522 serial port so the PMU SPI master path can be exercised in loopback (board self-test, simulation) without the device. It receives 29-bit frames on the PMU SPI pins (CPOL=0, CPHA=1, MSB first), holds a small register file, and returns register contents on the frame after a read request. It also emulates the BUSY_N and reset behaviour the master-side logic waits on. All sampling is done in the system clock domain, so SCLK must be slow relative to `clk`.

## Interface
- PMU_CFG_DW, 29, frame width in bits
- ADDR_DW, 4, register address width; the register file has 2^ADDR_DW entries
- REG_RST_VAL, 24'h400000, reset value of every register (mode bits [23:22] = 01)
- BUSY_CYCLES, 150, number of `clk` cycles BUSY_N stays low after a write or reset
- SYNC_STAGES, 2, synchronizer depth on SCLK, CSN and SDI

- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- pmu_spi_clk  in  1  SCLK from the master
- pmu_spi_csn  in  1  SYNC from the master, active low
- pmu_spi_sdi  in  1  MOSI from the master
- pmu_spi_sdo  out  1  MISO to the master
- pmu_rstn  in  1  emulated device reset, active low, asynchronous to the frame
- pmu_busyn  out  1  emulated BUSY_N
- wr_vld  out  1  one-cycle pulse when a register write is committed
- wr_addr  out  ADDR_DW  address of the committed write
- wr_data  out  24  data of the committed write
- frame_err  out  1  one-cycle pulse when a frame is discarded
- err_cnt  out  8  count of discarded frames, saturating at 255

## Operation
- Frame format (bit 28 first): [28] R/W (1 = read request), [27:24] address, [23:0] data. Frame bits [27:24] map to address bits [ADDR_DW-1:0]; any address bits above ADDR_DW-1 are ignored.
- SCLK, CSN and SDI each pass through SYNC_STAGES flops. SCLK rise and fall, and CSN fall and rise, are detected on the synchronized signals.
- Shift-in:
  - CSN fall clears the bit counter.
  - On each detected SCLK fall while CSN is low, the synchronized SDI is shifted in and the counter increments. The counter saturates at 31.
- Frame end is a detected CSN rise:
  - If the count is not 29, or `pmu_busyn` is 0: discard the frame, pulse `frame_err`, and increment `err_cnt`.
  - If R/W = 0: write data[23:0] to reg[addr], pulse `wr_vld` with `wr_addr`/`wr_data`, then drive `pmu_busyn` low for BUSY_CYCLES clocks.
  - If R/W = 1: latch the readback word {1'b0, addr, reg[addr]} into `rb_buf` and set `rb_pending`. There is no busy period.
- Shift-out:
  - On a detected CSN fall, load the shift-out register with `rb_buf` if `rb_pending` is set, otherwise with 0. Clear `rb_pending` at the same time.
  - `pmu_spi_sdo` presents bit 28 immediately.
  - After each detected SCLK fall, shift left so the next bit is presented.
  - While CSN is high, `pmu_spi_sdo` is 0.
- The frame that carries readback data is decoded normally, so it can be a write or another read.
- A new read request overwrites any unconsumed readback word.
- Device reset:
  - While `pmu_rstn` (synchronized) is 0: all registers return to REG_RST_VAL, `rb_pending` is cleared, frames are ignored (no error count), and `pmu_busyn` is 0.
  - On the `pmu_rstn` rise, `pmu_busyn` stays 0 for BUSY_CYCLES more clocks, then goes to 1.
- A busy counter is reloaded to BUSY_CYCLES by each new write; it does not accumulate.

## Timing
- Reset values:
  - `pmu_spi_sdo` = 0, `pmu_busyn` = 0, `wr_vld` = 0, `wr_addr` = 0, `wr_data` = 0, `frame_err` = 0, `err_cnt` = 0.
  - Registers = REG_RST_VAL.
  - After `rst` is released, `pmu_busyn` rises BUSY_CYCLES clocks later, provided `pmu_rstn` = 1.
- Edge detect latency: SYNC_STAGES + 1 clocks from a pin edge to the internal strobe.
- `pmu_spi_sdo` updates 1 clock after the strobe.
- `wr_vld` and `frame_err` are asserted 1 clock after the CSN-rise strobe.
- `pmu_busyn` falls in the same cycle as `wr_vld`.
- Supported SCLK: period ≥ 8 clk and each phase ≥ 4 clk (≤ 12.5 MHz at 100 MHz `clk`). The master must therefore use SPI_DIV ≥ 8 when talking to this block.
- CSN high time must be ≥ 4 clk between frames.
- Simultaneous events:
  - CSN rise and an SCLK fall strobe in the same cycle: the bit is shifted in first, then the frame is closed.
  - `rst` overrides everything.
  - `pmu_rstn` low during a frame: the frame is dropped silently.

## Test plan
- Release `rst` with `pmu_rstn` = 1 -> `pmu_busyn` = 0 for 150 clocks, then 1. All outputs stay at their reset values until then.
- Write 29'h0_5_400ABC (addr 5) -> `wr_vld` pulse with `wr_addr` = 5 and `wr_data` = 24'h400ABC; `pmu_busyn` low for 150 clocks.
- Read-request frame for addr 5, then a NOP frame -> the master captures 29'h05400ABC during the NOP frame. A second NOP frame returns 0.
- Read an unwritten addr 3 -> readback 29'h03400000, whose mode bits [23:22] = 01.
- Send a 28-bit frame, then a 30-bit frame -> two `frame_err` pulses, `err_cnt` = 2, no `wr_vld`, and no change to the register file.
- Write to addr 2, then hold `pmu_rstn` low for 400 clocks -> reading addr 2 returns 24'h400000 data. `pmu_busyn` rises 150 clocks after `pmu_rstn` goes high.

Source files
------------

// File: rtl/pmu_spi_slave_emu.sv
// AD5522 serial-port responder: 29-bit SPI frames into a 16x24 register file, readback on the next frame.
// Latency: pin edge to internal strobe SYNC_STAGES+1 clk; wr_vld/frame_err 1 clk after the CSN-rise strobe.
// No backpressure: frames closed while BUSY_N is low are discarded and counted in err_cnt.
module pmu_spi_slave_emu #(
    parameter int          PMU_CFG_DW  = 29,
    parameter int          ADDR_DW     = 4,
    parameter logic [23:0] REG_RST_VAL = 24'h400000,
    parameter int          BUSY_CYCLES = 150,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pmu_spi_clk,
    input  logic               pmu_spi_csn,
    input  logic               pmu_spi_sdi,
    output logic               pmu_spi_sdo,
    input  logic               pmu_rstn,
    output logic               pmu_busyn,
    output logic               wr_vld,
    output logic [ADDR_DW-1:0] wr_addr,
    output logic [23:0]        wr_data,
    output logic               frame_err,
    output logic [7:0]         err_cnt
);

    localparam int NREG   = 1 << ADDR_DW;
    localparam int BUSY_W = $clog2(BUSY_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, sdi_sync, rstn_sync;
    logic                   sclk_d, csn_d, sdi_d;
    logic                   sclk_fall_stb, csn_fall_stb, csn_rise_stb;
    logic                   rstn_s;

    logic                   in_frame;
    logic [4:0]             bit_cnt, cnt_nxt;
    logic [PMU_CFG_DW-1:0]  shreg, shreg_nxt;
    logic [PMU_CFG_DW-1:0]  sdo_sr;
    logic [PMU_CFG_DW-1:0]  rb_buf, rb_word;
    logic                   rb_pending;
    logic [23:0]            regs [NREG];
    logic [BUSY_W-1:0]      busy_cnt;

    logic                   frm_rd;
    logic [ADDR_DW-1:0]     frm_addr;
    logic [23:0]            frm_data;
    logic                   frame_end, frame_ok, wr_commit, rd_commit, bad_commit;

    assign rstn_s = rstn_sync[SYNC_STAGES-1];

    // Synchronize the pins and register the edge strobes (one extra flop on SDI keeps it aligned with the strobe)
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync     <= '0;
            csn_sync      <= '1;
            sdi_sync      <= '0;
            rstn_sync     <= '1;
            sclk_d        <= 1'b0;
            csn_d         <= 1'b1;
            sdi_d         <= 1'b0;
            sclk_fall_stb <= 1'b0;
            csn_fall_stb  <= 1'b0;
            csn_rise_stb  <= 1'b0;
        end else begin
            sclk_sync     <= {sclk_sync[SYNC_STAGES-2:0], pmu_spi_clk};
            csn_sync      <= {csn_sync[SYNC_STAGES-2:0], pmu_spi_csn};
            sdi_sync      <= {sdi_sync[SYNC_STAGES-2:0], pmu_spi_sdi};
            rstn_sync     <= {rstn_sync[SYNC_STAGES-2:0], pmu_rstn};
            sclk_d        <= sclk_sync[SYNC_STAGES-1];
            csn_d         <= csn_sync[SYNC_STAGES-1];
            sdi_d         <= sdi_sync[SYNC_STAGES-1];
            sclk_fall_stb <= sclk_d & ~sclk_sync[SYNC_STAGES-1];
            csn_fall_stb  <= csn_d & ~csn_sync[SYNC_STAGES-1];
            csn_rise_stb  <= ~csn_d & csn_sync[SYNC_STAGES-1];
        end
    end

    // Next shift state, so a bit arriving with the CSN-rise strobe is included in the frame being closed
    always_comb begin
        shreg_nxt = shreg;
        cnt_nxt   = bit_cnt;
        if (sclk_fall_stb && in_frame) begin
            shreg_nxt = {shreg[PMU_CFG_DW-2:0], sdi_d};
            if (bit_cnt != 5'd31) begin
                cnt_nxt = bit_cnt + 5'd1;
            end
        end
    end

    assign frm_rd     = shreg_nxt[PMU_CFG_DW-1];
    assign frm_addr   = shreg_nxt[24 +: ADDR_DW];
    assign frm_data   = shreg_nxt[23:0];
    assign rb_word    = PMU_CFG_DW'({1'b0, 4'(frm_addr), regs[frm_addr]});
    assign frame_end  = csn_rise_stb && in_frame && rstn_s;
    assign frame_ok   = (cnt_nxt == 5'(PMU_CFG_DW)) && pmu_busyn;
    assign wr_commit  = frame_end && frame_ok && !frm_rd;
    assign rd_commit  = frame_end && frame_ok && frm_rd;
    assign bad_commit = frame_end && !frame_ok;

    // Frame capture, decode, register file and readback shift-out
    always_ff @(posedge clk) begin
        if (rst) begin
            in_frame    <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            sdo_sr      <= '0;
            pmu_spi_sdo <= 1'b0;
            rb_buf      <= '0;
            rb_pending  <= 1'b0;
            wr_vld      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_err   <= 1'b0;
            err_cnt     <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= REG_RST_VAL;
            end
        end else begin
            wr_vld    <= 1'b0;
            frame_err <= 1'b0;
            bit_cnt   <= cnt_nxt;
            shreg     <= shreg_nxt;

            if (sclk_fall_stb && in_frame) begin
                sdo_sr      <= sdo_sr << 1;
                pmu_spi_sdo <= sdo_sr[PMU_CFG_DW-2];
            end

            // A frame is only opened while the emulated device is out of reset
            if (csn_fall_stb && rstn_s) begin
                in_frame    <= 1'b1;
                bit_cnt     <= '0;
                sdo_sr      <= rb_pending ? rb_buf : '0;
                pmu_spi_sdo <= rb_pending & rb_buf[PMU_CFG_DW-1];
                rb_pending  <= 1'b0;
            end

            if (csn_rise_stb) begin
                in_frame    <= 1'b0;
                pmu_spi_sdo <= 1'b0;
            end

            if (wr_commit) begin
                regs[frm_addr] <= frm_data;
                wr_vld         <= 1'b1;
                wr_addr        <= frm_addr;
                wr_data        <= frm_data;
            end

            if (rd_commit) begin
                rb_buf     <= rb_word;
                rb_pending <= 1'b1;
            end

            if (bad_commit) begin
                frame_err <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end

            // Device reset wipes state and silently drops any frame in flight
            if (!rstn_s) begin
                in_frame    <= 1'b0;
                pmu_spi_sdo <= 1'b0;
                rb_pending  <= 1'b0;
                for (int i = 0; i < NREG; i++) begin
                    regs[i] <= REG_RST_VAL;
                end
            end
        end
    end

    // BUSY_N: held low during device reset and reloaded (not extended) by each committed write
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt  <= BUSY_W'(BUSY_CYCLES);
            pmu_busyn <= 1'b0;
        end else if (!rstn_s || wr_commit) begin
            busy_cnt  <= BUSY_W'(BUSY_CYCLES);
            pmu_busyn <= 1'b0;
        end else if (busy_cnt != '0) begin
            busy_cnt  <= busy_cnt - BUSY_W'(1);
            pmu_busyn <= (busy_cnt == BUSY_W'(1));
        end
    end

endmodule
